// File: rtl/intra_pos_scheduler_pkg.sv
// Shared types and constants for the intra 4x4-position scheduler.
// Optional z-order scan is selected by INTRA_SCHED_ZSCAN_EN (see intra_blk_cnt).
package intra_sched_pkg;

  localparam int POS_W_DEF = 3;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] LOG2_MIN = 3'd2;
  localparam logic [2:0] LOG2_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Blocks-per-side exponent (log2Size - 2), with out-of-range sizes clamped.
  function automatic logic [1:0] size_shift(input logic [2:0] log2_size);
    logic [2:0] clamped;
    if (log2_size < LOG2_MIN) begin
      clamped = LOG2_MIN;
    end else if (log2_size > LOG2_MAX) begin
      clamped = LOG2_MAX;
    end else begin
      clamped = log2_size;
    end
    return 2'(clamped - LOG2_MIN);
  endfunction

endpackage

// File: rtl/intra_pos_scheduler_if.sv
// Job-request and position-output handshake bundle of the intra position scheduler.
// The scheduler uses the slave modport; the TU control / write-back side uses master.
interface intra_pos_scheduler_if #(
  parameter int POS_W = 3
) ();

  logic             start_valid;
  logic             start_ready;
  logic [2:0]       i_log2Size;
  logic [POS_W-1:0] i_baseX;
  logic [POS_W-1:0] i_baseY;
  logic             modeHor;
  logic             isInter;
  logic             flush;
  logic             o_valid;
  logic             o_ready;
  logic [POS_W-1:0] o_X;
  logic [POS_W-1:0] o_Y;
  logic             o_last;
  logic             done;

  modport master (
    output start_valid, i_log2Size, i_baseX, i_baseY, modeHor, isInter, flush, o_ready,
    input  start_ready, o_valid, o_X, o_Y, o_last, done
  );

  modport slave (
    input  start_valid, i_log2Size, i_baseX, i_baseY, modeHor, isInter, flush, o_ready,
    output start_ready, o_valid, o_X, o_Y, o_last, done
  );

endinterface

// File: rtl/intra_blk_cnt.sv
// Block counter with relative X/Y decode of its *next* value, so the top can register outputs.
// Raster order by default; z-order when INTRA_SCHED_ZSCAN_EN is defined.
module intra_blk_cnt #(
  parameter int POS_W = 3,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [1:0]       shift,
  output logic [POS_W-1:0] rel_x,
  output logic [POS_W-1:0] rel_y,
  output logic             last
);

  logic [CNT_W-1:0] c_q;
  logic [CNT_W-1:0] c_d;
  logic [POS_W-1:0] mask;
  logic [CNT_W-1:0] last_cnt;
  logic [POS_W-1:0] rx_raw;
  logic [POS_W-1:0] ry_raw;

  always_comb begin
    c_d = c_q;
    if (clr) begin
      c_d = '0;
    end else if (inc) begin
      c_d = c_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign mask     = ~({POS_W{1'b1}} << shift);
  assign last_cnt = ~({CNT_W{1'b1}} << {shift, 1'b0});

`ifdef INTRA_SCHED_ZSCAN_EN
  // Interleaved bits: even count bits form X, odd bits form Y.
  for (genvar gi = 0; gi < POS_W; gi++) begin : g_zdec
    assign rx_raw[gi] = c_d[2*gi];
    assign ry_raw[gi] = c_d[2*gi+1];
  end
`else
  assign rx_raw = c_d[POS_W-1:0];
  assign ry_raw = POS_W'(c_d >> shift);
`endif

  assign rel_x = rx_raw & mask;
  assign rel_y = ry_raw & mask;
  assign last  = (c_d == last_cnt);

endmodule

// File: rtl/intra_pos_scheduler.sv
// Emits the 4x4-block grid positions of one TU per handshake, with horizontal-mode transpose.
// Build option INTRA_SCHED_ZSCAN_EN switches the scan from raster to z-order.
module intra_pos_scheduler
  import intra_sched_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  intra_pos_scheduler_if.slave  bus
);

  state_e           state_q, state_d;
  logic [1:0]       shift_q, shift_d;
  logic [POS_W-1:0] base_x_q, base_x_d;
  logic [POS_W-1:0] base_y_q, base_y_d;
  logic             swap_q, swap_d;
  logic             start_ready_q, start_ready_d;
  logic             o_valid_q, o_valid_d;
  logic [POS_W-1:0] o_x_q, o_x_d;
  logic [POS_W-1:0] o_y_q, o_y_d;
  logic             o_last_q, o_last_d;
  logic             done_q, done_d;

  logic             accept;
  logic             cnt_inc;
  logic [1:0]       new_shift;
  logic [POS_W-1:0] new_mask;
  logic [POS_W-1:0] rel_x, rel_y;
  logic             cnt_last;

  assign accept    = (state_q == IDLE) && !bus.flush && bus.start_valid;
  assign new_shift = size_shift(bus.i_log2Size);
  assign new_mask  = ~({POS_W{1'b1}} << new_shift);

  // Job parameters: loaded on accept, base aligned down to the TU size.
  always_comb begin
    shift_d  = shift_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    swap_d   = swap_q;
    if (accept) begin
      shift_d  = new_shift;
      base_x_d = bus.i_baseX & ~new_mask;
      base_y_d = bus.i_baseY & ~new_mask;
      swap_d   = bus.modeHor && !bus.isInter;
    end
  end

  intra_blk_cnt #(
    .POS_W (POS_W),
    .CNT_W (CNT_W)
  ) u_blk_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (cnt_inc),
    .shift (shift_d),
    .rel_x (rel_x),
    .rel_y (rel_y),
    .last  (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    start_ready_d = start_ready_q;
    o_valid_d     = o_valid_q;
    o_x_d         = o_x_q;
    o_y_d         = o_y_q;
    o_last_d      = o_last_q;
    done_d        = 1'b0;
    cnt_inc       = 1'b0;

    if (bus.flush) begin
      state_d       = IDLE;
      start_ready_d = 1'b1;
      o_valid_d     = 1'b0;
      o_last_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            state_d       = RUN;
            start_ready_d = 1'b0;
            o_valid_d     = 1'b1;
          end
        end
        RUN: begin
          if (o_valid_q && bus.o_ready) begin
            if (o_last_q) begin
              state_d   = DONE;
              o_valid_d = 1'b0;
              o_last_d  = 1'b0;
              done_d    = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        DONE: begin
          state_d       = IDLE;
          start_ready_d = 1'b1;
        end
        default: begin
          state_d       = IDLE;
          start_ready_d = 1'b1;
          o_valid_d     = 1'b0;
          o_last_d      = 1'b0;
        end
      endcase
    end

    // Position registers only move when a new position is produced, so they hold under stall.
    if (accept || cnt_inc) begin
      o_x_d    = base_x_d + (swap_d ? rel_y : rel_x);
      o_y_d    = base_y_d + (swap_d ? rel_x : rel_y);
      o_last_d = cnt_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      base_x_q      <= '0;
      base_y_q      <= '0;
      swap_q        <= 1'b0;
      start_ready_q <= 1'b1;
      o_valid_q     <= 1'b0;
      o_x_q         <= '0;
      o_y_q         <= '0;
      o_last_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      base_x_q      <= base_x_d;
      base_y_q      <= base_y_d;
      swap_q        <= swap_d;
      start_ready_q <= start_ready_d;
      o_valid_q     <= o_valid_d;
      o_x_q         <= o_x_d;
      o_y_q         <= o_y_d;
      o_last_q      <= o_last_d;
      done_q        <= done_d;
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_X         = o_x_q;
  assign bus.o_Y         = o_y_q;
  assign bus.o_last      = o_last_q;
  assign bus.done        = done_q;

endmodule
